apuracao: RTL and testbench
===========================

APURACAO -- requirements
Module: apuracao

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have ports: candidatoArthur, candidatoLeandro, candidatoMateus, candidatoPablo, candidatoNulo  in  1 each  level vote flags from ballot stage, held high until next vote starts.
REQ-004 SHALL have ports: votoValido  in  2  1 = named-candidate vote, 3 = null vote, 0 = none.
REQ-005 SHALL have ports: finish  in  1  high = polls closed, request tally.
REQ-006 SHALL have ports: sel  in  3  count read select (0 Arthur, 1 Leandro, 2 Mateus, 3 Pablo, 4 Nulo).
REQ-007 SHALL have ports: contagem  out  8  count of candidate addressed by sel, combinational read.
REQ-008 SHALL have ports: total  out  10  sum of all accepted votes, including null.
REQ-009 SHALL have ports: vencedor  out  3  winner code (0..3), 7 = none.
REQ-010 SHALL have ports: empate  out  1  tie for highest count.
REQ-011 SHALL have ports: resultadoPronto  out  1  vencedor/empate valid.

Function
REQ-012 SHALL run a state machine CONTANDO -> APURANDO -> RESULTADO.
REQ-013 In CONTANDO, SHALL count one vote per 0->1 edge of a candidate flag, using a registered previous-value copy; a level held high counts once.
REQ-014 Edge accepted only if votoValido matches: 1 for named candidates, 3 for Nulo; otherwise ignored.
REQ-015 Simultaneous rising edges: only the highest priority is counted (Arthur > Leandro > Mateus > Pablo > Nulo).
REQ-016 Count update occurs the cycle after the edge is seen; total increments in the same cycle.
REQ-017 finish rising edge in CONTANDO SHALL move to APURANDO; resultadoPronto goes 0.
REQ-018 APURANDO SHALL scan indices 0..3, one per cycle (4 cycles): count > best -> best = count, vencedor = index, empate = 0; count == best and best > 0 -> empate = 1.
REQ-019 After index 3, SHALL enter RESULTADO with resultadoPronto = 1; result latency = 5 cycles from the finish edge.
REQ-020 All counts zero SHALL give vencedor = 7, empate = 0.
REQ-021 Votes arriving in APURANDO or RESULTADO SHALL be ignored; edge-detect registers still track inputs, so no stale edge fires on return.
REQ-022 finish low in RESULTADO SHALL return to CONTANDO; counts are retained and resultadoPronto clears.
REQ-023 finish falling during APURANDO: the scan completes, then RESULTADO, then REQ-022 applies.
REQ-024 sel values 5..7 SHALL read contagem = 0.
REQ-025 total SHALL saturate at 1023.

Reset
REQ-026 reset low SHALL asynchronously clear counts, total, edge registers and empate; state = CONTANDO, vencedor = 7, resultadoPronto = 0.
REQ-027 reset mid-APURANDO SHALL abort the scan with no partial result visible.

Configuration
REQ-028 Macro APURACAO_SATURATE_EN defined: candidate counts saturate at 255 (further votes ignored, total still increments).
REQ-029 Macro APURACAO_SATURATE_EN undefined: candidate counts wrap modulo 256.

Structure
REQ-030 Shared package urna_pkg SHALL hold candidate index codes, NENHUM = 7, state encodings and the count width constant (8).
REQ-031 SHALL instantiate five copies of sub-module contador_voto (edge detect plus 8-bit counter, saturation per macro).

Verification
REQ-032 Arthur edges x3 with votoValido = 1, Pablo x1, finish -> after 5 cycles vencedor = 0, empate = 0, total = 4, resultadoPronto = 1.
REQ-033 Mateus x2, Leandro x2, finish -> vencedor = 1, empate = 1.
REQ-034 No votes, finish -> vencedor = 7, empate = 0, total = 0.
REQ-035 Arthur and Nulo rise in the same cycle -> Arthur = 1, Nulo = 0, total = 1; flag held high 10 cycles -> still 1.
REQ-036 300 Leandro edges -> contagem (sel = 1) = 255 with macro, 44 without; total = 300.
REQ-037 reset pulsed low on the 2nd APURANDO cycle -> all counts 0, vencedor = 7, resultadoPronto stays 0.

Source files
------------

// File: rtl/urna_pkg.sv
// Shared constants for the vote-tally block: candidate codes, FSM states, widths.
// Pure declarations, no logic.
// Imported by apuracao and contador_voto.
package urna_pkg;

  localparam int CNT_W  = 8;
  localparam int TOT_W  = 10;
  localparam int N_CAND = 5;

  localparam logic [2:0] IDX_ARTHUR  = 3'd0;
  localparam logic [2:0] IDX_LEANDRO = 3'd1;
  localparam logic [2:0] IDX_MATEUS  = 3'd2;
  localparam logic [2:0] IDX_PABLO   = 3'd3;
  localparam logic [2:0] IDX_NULO    = 3'd4;
  localparam logic [2:0] NENHUM      = 3'd7;

  localparam logic [1:0] VOTO_NOMINAL = 2'd1;
  localparam logic [1:0] VOTO_NULO    = 2'd3;

  typedef enum logic [1:0] {
    CONTANDO  = 2'd0,
    APURANDO  = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_voto.sv
// Per-candidate rising-edge detector plus 8-bit vote counter.
// Latency: count updates on the clock edge that first samples the flag high.
// Config: APURACAO_SATURATE_EN makes the count stick at 255, otherwise it wraps.
module contador_voto
  import urna_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flag,
  input  logic             enable,
  output logic             rise,
  output logic [CNT_W-1:0] count
);

  logic prev;

  assign rise = flag & ~prev;

  // Edge register always follows the flag; count advances only when granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev  <= 1'b0;
      count <= '0;
    end else begin
      prev <= flag;
`ifdef APURACAO_SATURATE_EN
      if (enable && (count != '1)) count <= count + 1'b1;
`else
      if (enable) count <= count + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/apuracao.sv
// Ballot tally: counts edge-qualified votes, then scans counts 0..3 for winner/tie.
// Latency: count +1 cycle after edge; result 5 cycles after the finish rising edge.
// Config: APURACAO_SATURATE_EN selects saturating (vs wrapping) candidate counts.
module apuracao
  import urna_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             candidatoArthur,
  input  logic             candidatoLeandro,
  input  logic             candidatoMateus,
  input  logic             candidatoPablo,
  input  logic             candidatoNulo,
  input  logic [1:0]       votoValido,
  input  logic             finish,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] contagem,
  output logic [TOT_W-1:0] total,
  output logic [2:0]       vencedor,
  output logic             empate,
  output logic             resultadoPronto
);

  estado_t state, state_nx;

  logic [N_CAND-1:0] flags, rise, acc, grant, enable;
  logic [CNT_W-1:0]  cnt [N_CAND];
  logic              fin_prev, fin_rise;
  logic              counting, scanning, start, scan_last;

  logic [1:0]        idx;
  logic [CNT_W-1:0]  best, best_nx, cur;
  logic [2:0]        win, win_nx;
  logic              tie, tie_nx;

  assign flags = {candidatoNulo, candidatoPablo, candidatoMateus,
                  candidatoLeandro, candidatoArthur};

  // Named candidates need votoValido=1, Nulo needs 3; lowest index wins ties.
  assign acc    = rise & {votoValido == VOTO_NULO, {4{votoValido == VOTO_NOMINAL}}};
  assign grant  = acc & (~acc + 5'd1);
  assign enable = grant & {N_CAND{counting}};

  for (genvar g = 0; g < N_CAND; g++) begin : g_cont
    contador_voto u_cont (
      .clock  (clock),
      .reset  (reset),
      .flag   (flags[g]),
      .enable (enable[g]),
      .rise   (rise[g]),
      .count  (cnt[g])
    );
  end

  assign fin_rise  = finish & ~fin_prev;
  assign scan_last = scanning && (idx == 2'd3);

  // State register plus finish edge tracker (tracked in every state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= CONTANDO;
      fin_prev <= 1'b0;
    end else begin
      state    <= state_nx;
      fin_prev <= finish;
    end
  end

  // Next-state: count until finish rises, scan four slots, hold until finish drops.
  always_comb begin
    state_nx = state;
    case (state)
      CONTANDO:  if (fin_rise)  state_nx = APURANDO;
      APURANDO:  if (scan_last) state_nx = RESULTADO;
      RESULTADO: if (!finish)   state_nx = CONTANDO;
      default:                  state_nx = CONTANDO;
    endcase
  end

  // FSM-decoded controls.
  always_comb begin
    counting        = (state == CONTANDO);
    scanning        = (state == APURANDO);
    resultadoPronto = (state == RESULTADO);
    start           = counting && fin_rise;
  end

  // One compare step of the winner scan on the slot addressed by idx.
  always_comb begin
    case (idx)
      2'd0:    cur = cnt[0];
      2'd1:    cur = cnt[1];
      2'd2:    cur = cnt[2];
      default: cur = cnt[3];
    endcase
    best_nx = best;
    win_nx  = win;
    tie_nx  = tie;
    if (cur > best) begin
      best_nx = cur;
      win_nx  = {1'b0, idx};
      tie_nx  = 1'b0;
    end else if ((cur == best) && (best != '0)) begin
      tie_nx = 1'b1;
    end
  end

  // Scan working registers; published result only changes on the final slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= 2'd0;
      best     <= '0;
      win      <= NENHUM;
      tie      <= 1'b0;
      vencedor <= NENHUM;
      empate   <= 1'b0;
    end else if (start) begin
      idx  <= 2'd0;
      best <= '0;
      win  <= NENHUM;
      tie  <= 1'b0;
    end else if (scanning) begin
      idx  <= idx + 2'd1;
      best <= best_nx;
      win  <= win_nx;
      tie  <= tie_nx;
      if (scan_last) begin
        vencedor <= win_nx;
        empate   <= tie_nx;
      end
    end
  end

  // Total of accepted votes, saturating at full scale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total <= '0;
    end else if ((|enable) && (total != '1)) begin
      total <= total + 1'b1;
    end
  end

  // Combinational count readback; unused select codes read zero.
  always_comb begin
    contagem = '0;
    case (sel)
      IDX_ARTHUR:  contagem = cnt[0];
      IDX_LEANDRO: contagem = cnt[1];
      IDX_MATEUS:  contagem = cnt[2];
      IDX_PABLO:   contagem = cnt[3];
      IDX_NULO:    contagem = cnt[4];
      default:     contagem = '0;
    endcase
  end

endmodule

// File: tb/tb_apuracao.sv
// Self-checking bench for apuracao: election-level model plus directed scenarios.
module tb_apuracao;

  logic       clock, reset;
  logic [4:0] flags_in;
  logic [1:0] voto;
  logic       fin_in;
  logic [2:0] sel;
  logic [7:0] contagem;
  logic [9:0] total;
  logic [2:0] vencedor;
  logic       empate, resultadoPronto;

  apuracao dut (
    .clock            (clock),
    .reset            (reset),
    .candidatoArthur  (flags_in[0]),
    .candidatoLeandro (flags_in[1]),
    .candidatoMateus  (flags_in[2]),
    .candidatoPablo   (flags_in[3]),
    .candidatoNulo    (flags_in[4]),
    .votoValido       (voto),
    .finish           (fin_in),
    .sel              (sel),
    .contagem         (contagem),
    .total            (total),
    .vencedor         (vencedor),
    .empate           (empate),
    .resultadoPronto  (resultadoPronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Election model: ballots, running total, and the published result.
  int         mcnt [5];
  int         mtotal;
  logic [4:0] mprev;
  logic       mfin;
  int         phase;      // 0 counting, 1 tallying, 2 result shown
  int         scan_left;
  logic       mready;
  int         mwin;
  logic       mtie;
  logic [2:0] cur_sel;
  logic       chk_en;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic bump(input int i);
`ifdef APURACAO_SATURATE_EN
    if (mcnt[i] < 255) mcnt[i] = mcnt[i] + 1;
`else
    mcnt[i] = (mcnt[i] + 1) % 256;
`endif
  endtask

  // Winner = highest of the four named candidates, first one on a tie.
  task automatic decide();
    int mx, n;
    mx = 0; n = 0; mwin = 7;
    for (int i = 0; i < 4; i++) if (mcnt[i] > mx) mx = mcnt[i];
    if (mx == 0) begin
      mwin = 7; mtie = 1'b0;
    end else begin
      for (int i = 3; i >= 0; i--) if (mcnt[i] == mx) begin mwin = i; n++; end
      mtie = (n > 1);
    end
  endtask

  task automatic tick();
    logic [4:0] r;
    int w;
    @(posedge clock);
    if (!reset) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mtotal = 0; mprev = '0; mfin = 1'b0; phase = 0;
      scan_left = 0; mready = 1'b0; mwin = 7; mtie = 1'b0;
    end else begin
      r = flags_in & ~mprev;
      mprev = flags_in;
      if (phase == 0) begin
        w = -1;
        for (int i = 0; i < 5; i++)
          if (w < 0 && r[i] && ((i < 4 && voto == 2'd1) || (i == 4 && voto == 2'd3))) w = i;
        if (w >= 0) begin
          bump(w);
          mtotal = (mtotal < 1023) ? mtotal + 1 : 1023;
        end
        if (fin_in && !mfin) begin phase = 1; scan_left = 4; mready = 1'b0; end
      end else if (phase == 1) begin
        scan_left--;
        if (scan_left == 0) begin phase = 2; mready = 1'b1; decide(); end
      end else if (!fin_in) begin
        phase = 0; mready = 1'b0;
      end
      mfin = fin_in;
    end
  endtask

  task automatic step(input logic [4:0] f, input logic [1:0] vv, input logic fin);
    @(negedge clock);
    flags_in = f; voto = vv; fin_in = fin; sel = cur_sel;
    tick();
  endtask

  task automatic vote(input logic [4:0] f, input logic [1:0] vv);
    step(f, vv, 1'b0);
    step(5'd0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; flags_in = '0; voto = '0; fin_in = 1'b0;
    tick();
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic finish_run();
    repeat (4) step(5'd0, 2'd0, 1'b1);
    #1 chk("latency_not_ready_at_4", int'(resultadoPronto), 0);
    step(5'd0, 2'd0, 1'b1);
    #1 chk("latency_ready_at_5", int'(resultadoPronto), 1);
  endtask

  // Every-cycle comparison against the model.
  always begin
    @(posedge clock);
    #1;
    if (chk_en) begin
      chk("total", int'(total), mtotal);
      chk("contagem", int'(contagem), (sel < 3'd5) ? mcnt[sel] : 0);
      chk("resultadoPronto", int'(resultadoPronto), int'(mready));
      if (mready) begin
        chk("vencedor", int'(vencedor), mwin);
        chk("empate", int'(empate), int'(mtie));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flags_in = '0; voto = '0; fin_in = 1'b0; sel = '0;
    cur_sel = '0; chk_en = 1'b0;
    tick();
    #1;
    chk("rst_vencedor", int'(vencedor), 7);
    chk("rst_empate", int'(empate), 0);
    chk("rst_pronto", int'(resultadoPronto), 0);
    chk("rst_total", int'(total), 0);
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;

    // Arthur x3, Pablo x1 -> Arthur wins outright.
    repeat (3) vote(5'b00001, 2'd1);
    vote(5'b01000, 2'd1);
    finish_run();
    chk("t032_vencedor", int'(vencedor), 0);
    chk("t032_empate", int'(empate), 0);
    chk("t032_total", int'(total), 4);
    step(5'd0, 2'd0, 1'b0);
    #1 chk("t032_pronto_cleared", int'(resultadoPronto), 0);

    // Mateus x2, Leandro x2 -> tie, Leandro reported.
    do_reset();
    repeat (2) vote(5'b00100, 2'd1);
    repeat (2) vote(5'b00010, 2'd1);
    finish_run();
    chk("t033_vencedor", int'(vencedor), 1);
    chk("t033_empate", int'(empate), 1);
    // Arthur rises while the result is shown and stays high across the return.
    step(5'b00001, 2'd1, 1'b1);
    step(5'b00001, 2'd1, 1'b0);
    repeat (3) step(5'b00001, 2'd1, 1'b0);
    step(5'd0, 2'd0, 1'b0);
    cur_sel = 3'd0;
    step(5'd0, 2'd0, 1'b0);
    #1 chk("t033_no_stale_edge", int'(contagem), 0);
    chk("t033_total_kept", int'(total), 4);

    // No votes -> no winner; also finish dropping mid-scan.
    do_reset();
    finish_run();
    chk("t034_vencedor", int'(vencedor), 7);
    chk("t034_empate", int'(empate), 0);
    chk("t034_total", int'(total), 0);
    step(5'd0, 2'd0, 1'b0);
    step(5'd0, 2'd0, 1'b1);
    repeat (3) step(5'd0, 2'd0, 1'b0);
    #1 chk("t023_scan_running", int'(resultadoPronto), 0);
    step(5'd0, 2'd0, 1'b0);
    #1 chk("t023_result_shown", int'(resultadoPronto), 1);
    step(5'd0, 2'd0, 1'b0);
    #1 chk("t023_back_to_count", int'(resultadoPronto), 0);

    // Arthur and Nulo rise together; flag held 10 cycles.
    do_reset();
    cur_sel = 3'd0;
    repeat (11) step(5'b10001, 2'd1, 1'b0);
    #1 chk("t035_arthur_held", int'(contagem), 1);
    step(5'd0, 2'd0, 1'b0);
    cur_sel = 3'd4;
    step(5'd0, 2'd0, 1'b0);
    #1 chk("t035_nulo", int'(contagem), 0);
    chk("t035_total", int'(total), 1);
    vote(5'b00001, 2'd3);   // named candidate with null code: ignored
    vote(5'b00010, 2'd0);   // no vote code: ignored
    vote(5'b10000, 2'd1);   // Nulo with named code: ignored
    vote(5'b10000, 2'd3);   // valid null vote
    #1 chk("t035_nulo_valid", int'(contagem), 1);
    chk("t035_total2", int'(total), 2);
    cur_sel = 3'd5;
    step(5'd0, 2'd0, 1'b0);
    #1 chk("sel5_zero", int'(contagem), 0);
    cur_sel = 3'd7;
    step(5'd0, 2'd0, 1'b0);
    #1 chk("sel7_zero", int'(contagem), 0);

    // 300 Leandro votes: wrap or saturate; then push total past 1023.
    do_reset();
    cur_sel = 3'd1;
    repeat (300) vote(5'b00010, 2'd1);
`ifdef APURACAO_SATURATE_EN
    #1 chk("t036_leandro", int'(contagem), 255);
`else
    #1 chk("t036_leandro", int'(contagem), 44);
`endif
    chk("t036_total", int'(total), 300);
    repeat (800) vote(5'b01000, 2'd1);
    #1 chk("total_saturates", int'(total), 1023);

    // Reset on the second tally cycle aborts the scan.
    step(5'd0, 2'd0, 1'b1);
    step(5'd0, 2'd0, 1'b1);
    do_reset();
    #1 chk("t037_leandro", int'(contagem), 0);
    chk("t037_vencedor", int'(vencedor), 7);
    chk("t037_pronto", int'(resultadoPronto), 0);
    chk("t037_total", int'(total), 0);
    repeat (6) step(5'd0, 2'd0, 1'b0);
    #1 chk("t037_pronto_stays", int'(resultadoPronto), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
